// File: rtl/io_stream_buffer_if.sv
// Word handshakes between the core, the buffer and the serial device.
// The buffer takes the slave view; whatever drives the core and device sides takes the master view.
interface io_stream_buffer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] cpu_out_data;
  logic              cpu_out_vld;
  logic              cpu_out_rdy;
  logic [DATA_W-1:0] cpu_in_data;
  logic              cpu_in_vld;
  logic              cpu_in_rdy;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_vld;
  logic              io_out_rdy;
  logic [DATA_W-1:0] io_in_data;
  logic              io_in_vld;
  logic              io_in_rdy;

  modport slave (
    input  cpu_out_data, cpu_out_vld, cpu_in_rdy, io_out_rdy, io_in_data, io_in_vld,
    output cpu_out_rdy, cpu_in_data, cpu_in_vld, io_out_data, io_out_vld, io_in_rdy
  );

  modport master (
    output cpu_out_data, cpu_out_vld, cpu_in_rdy, io_out_rdy, io_in_data, io_in_vld,
    input  cpu_out_rdy, cpu_in_data, cpu_in_vld, io_out_data, io_out_vld, io_in_rdy
  );
endinterface

// File: rtl/io_stream_buffer.sv
// Buffered IO front-end: independent show-ahead TX and RX FIFOs with flush,
// occupancy counts and a sticky error register in the core's err encoding.
module io_stream_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // Handshake outputs depend on registered pointers only, never on the far side.
  assign wr_rdy  = !full;
  assign rd_vld  = !empty;
  assign push    = wr_vld && wr_rdy;
  assign pop     = rd_vld && rd_rdy;
  assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign count   = wr_ptr - rd_ptr;

  // Storage is cleared on reset so the show-ahead head never reads back X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

module io_stream_buffer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  io_stream_buffer_if.slave     bus,
  input  logic [4:0]            io_err,
  input  logic                  tx_flush,
  input  logic                  rx_flush,
  input  logic                  err_clr,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [7:0]            err
);
  logic [7:0] err_set;

  io_stream_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_data (bus.cpu_out_data),
    .wr_vld  (bus.cpu_out_vld),
    .wr_rdy  (bus.cpu_out_rdy),
    .rd_data (bus.io_out_data),
    .rd_vld  (bus.io_out_vld),
    .rd_rdy  (bus.io_out_rdy),
    .flush   (tx_flush),
    .count   (tx_count)
  );

  io_stream_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_data (bus.io_in_data),
    .wr_vld  (bus.io_in_vld),
    .wr_rdy  (bus.io_in_rdy),
    .rd_data (bus.cpu_in_data),
    .rd_vld  (bus.cpu_in_vld),
    .rd_rdy  (bus.cpu_in_rdy),
    .flush   (rx_flush),
    .count   (rx_count)
  );

  // bit7 lost word (device ignored io_in_rdy), bit6 reserved, bit5 any io_err, bits4:0 io_err.
  assign err_set = {bus.io_in_vld && !bus.io_in_rdy, 1'b0, |io_err, io_err};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        err <= '0;
    else if (err_clr) err <= err_set;
    else              err <= err | err_set;
  end
endmodule
